// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and buffer geometry.
package uart_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned RX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through byte FIFO for the UART receiver.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RX_FIFO_DEPTH));
  assign dout    = mem[rd_ptr];

  // A pop on empty is ignored; a push into a full FIFO only lands if a pop frees a slot.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage, pointers (wrap naturally modulo depth) and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(RX_FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with a 4-entry receive buffer, framing-error and overrun pulses.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam int unsigned IDX_W = 3;

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;

  logic              rx_q1;
  logic              rx_s;
  logic              rx_prev;
  logic              rx_fall_c;
  logic              push_c;
  logic              pop_c;
  logic              fifo_empty;
  logic              fifo_full;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_q1   <= rx;
      rx_s    <= rx_q1;
      rx_prev <= rx_s;
    end
  end

  // A new start needs a genuine 1->0 edge, so a low line after a framing error cannot retrigger.
  assign rx_fall_c = rx_prev && !rx_s;

  // Receive FSM: mid-bit sampling driven by the bit-period down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fall_c) begin
            state <= START;
            cnt   <= CNT_W'(DIV / 2 - 1);
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= CNT_W'(DIV - 1);
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[DATA_W-1:1]};
            cnt   <= CNT_W'(DIV - 1);
            idx   <= idx + 1'b1;
            if (idx == IDX_W'(7)) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            frame_err <= !rx_s;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Good stop bit pushes the assembled byte in the same cycle it is sampled.
  assign push_c = (state == STOP) && (cnt == '0) && rx_s;
  assign pop_c  = dout_valid && dout_ready;

  // Overrun: a good byte arrives while full and no pop frees a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push_c && fifo_full && !pop_c;
    end
  end

  assign dout_valid = !fifo_empty;
  assign busy       = (state != IDLE);

  uart_rx_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   (shreg),
    .pop   (pop_c),
    .dout  (dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Scoreboard bench for uart_rx_buf at the default 104 clocks per bit.
module tb_uart_rx_buf;

  localparam int DIV = 104;
  // Clock edges from the line falling (driven just after edge 0) to the stop-bit sample:
  // 2 synchronizer stages + edge detect, half a bit in START, then nine full bit periods.
  localparam int STOP_EDGE = 3 + DIV / 2 + 9 * DIV;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks;
  int errors;
  int fe_cnt;
  int ov_cnt;
  logic [7:0] exp_q[$];

  uart_rx_buf dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pops the scoreboard whenever the consumer accepts a byte; counts flag pulses.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_byte actual=%0h required=none", dout);
          end else begin
            check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
          end
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serializes one 8N1 frame; cycle index c counts edges since the start bit was driven.
  task automatic send_byte(input logic [7:0] data, input logic stop,
                           input bit chk_lat, input bit pop_at_stop);
    for (int c = 0; c < 10 * DIV; c++) begin
      automatic int b = c / DIV;
      rx = (b == 0) ? 1'b0 : (b == 9) ? stop : data[b-1];
      if (chk_lat && c == 5 * DIV) check("busy_mid_frame", 32'(busy), 32'd1);
      if (chk_lat && c == STOP_EDGE - 1) check("valid_before_stop", 32'(dout_valid), 32'd0);
      if (chk_lat && c == STOP_EDGE) begin
        check("valid_after_stop", 32'(dout_valid), 32'd1);
        check("dout_after_stop", 32'(dout), 32'(data));
      end
      if (pop_at_stop) dout_ready = (c == STOP_EDGE - 1);
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic read_n(input int n);
    dout_ready = 1'b1;
    cycles(n);
    dout_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    rst = 1'b1;
    rx = 1'b1;
    dout_ready = 1'b0;
    fork
      monitor();
    join_none

    cycles(3);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({frame_err, overrun}), 32'd0);
    rst = 1'b0;
    cycles(5);

    // Single byte, consumer stalled, latency of one cycle after the stop sample.
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
    check("a5_valid", 32'(dout_valid), 32'd1);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_no_flags", 32'(fe_cnt + ov_cnt), 32'd0);
    read_n(1);
    check("a5_drained", 32'(dout_valid), 32'd0);
    cycles(DIV);

    // False start: 20-clock glitch aborts at the START mid-point.
    rx = 1'b0;
    cycles(10);
    check("glitch_busy", 32'(busy), 32'd1);
    cycles(10);
    rx = 1'b1;
    cycles(60);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_no_push", 32'(dout_valid), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt), 32'd0);
    cycles(DIV);

    // Framing error then recovery with a good frame.
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
    cycles(DIV);
    check("fe_once", 32'(fe_cnt), 32'd1);
    check("fe_no_push", 32'(dout_valid), 32'd0);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b1, 1'b0);
    check("fe_recover_fe", 32'(fe_cnt), 32'd1);
    read_n(1);
    cycles(DIV);

    // Overrun on the fifth byte with the consumer stalled.
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b0, 1'b0);
    end
    check("ov_none_yet", 32'(ov_cnt), 32'd0);
    send_byte(8'h05, 1'b1, 1'b0, 1'b0);
    check("ov_pulse", 32'(ov_cnt), 32'd1);
    read_n(4);
    check("ov_drained", 32'(dout_valid), 32'd0);
    check("ov_sb_empty", 32'(exp_q.size()), 32'd0);
    cycles(DIV);

    // Full FIFO with a pop exactly on the stop-sample cycle: push lands, no overrun.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h11 + 8'(i));
      send_byte(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0);
    end
    exp_q.push_back(8'h15);
    send_byte(8'h15, 1'b1, 1'b0, 1'b1);
    check("full_pop_no_ov", 32'(ov_cnt), 32'd1);
    check("full_pop_sb_left", 32'(exp_q.size()), 32'd4);
    read_n(4);
    check("full_pop_count4", 32'(dout_valid), 32'd0);
    cycles(DIV);

    // Reset in the middle of DATA bit 4 of 8'hFF while a byte is buffered.
    exp_q.push_back(8'h77);
    send_byte(8'h77, 1'b1, 1'b0, 1'b0);
    rx = 1'b0;
    cycles(DIV);
    rx = 1'b1;
    cycles(4 * DIV + DIV / 2);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'h00);
    check("mid_rst_flags", 32'({frame_err, overrun}), 32'd0);
    cycles(3);
    rst = 1'b0;
    cycles(2 * DIV);
    check("post_rst_no_byte", 32'(dout_valid), 32'd0);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("final_fe_total", 32'(fe_cnt), 32'd1);
    check("final_ov_total", 32'(ov_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
